// File: rtl/fc_loss_grad_if.sv
// Bundle between fc_loss_grad and its neighbours: the forward-pass sample stream,
// the label, the class result and the backward-pass error stream.
interface fc_loss_grad_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 10
);
    logic                     forward;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic        [IDX_W-1:0]  in_idx;
    logic                     in_rdy;
    logic        [IDX_W-1:0]  label;
    logic                     label_valid;
    logic        [IDX_W-1:0]  class_out;
    logic                     class_valid;
    logic signed [DATA_W-1:0] err_data;
    logic        [IDX_W-1:0]  err_idx;
    logic                     err_valid;
    logic                     err_rdy;
    logic                     busy;

    modport slave (
        input  forward, in_valid, in_data, in_idx, label, label_valid, err_rdy,
        output in_rdy, class_out, class_valid, err_data, err_idx, err_valid, busy
    );

    modport master (
        output forward, in_valid, in_data, in_idx, label, label_valid, err_rdy,
        input  in_rdy, class_out, class_valid, err_data, err_idx, err_valid, busy
    );
endinterface

// File: rtl/fc_loss_grad.sv
// Loss-gradient stage behind the fc layer: buffers the forward outputs, reports the
// argmax class, then streams err[i] = y[i] - onehot(label)[i] back to the fc layer.
module fc_loss_grad #(
    parameter int N_OUT  = 10,
    parameter int IDX_W  = 10,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    fc_loss_grad_if.slave bus
);

    localparam int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] ONE      = DATA_W'(65536);

    typedef enum logic [1:0] {COLLECT, RESULT, WAIT_BWD, EMIT} state_t;

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [DATA_W:0] v);
        if (v[DATA_W] != v[DATA_W-1]) sat = v[DATA_W] ? MOST_NEG : MOST_POS;
        else                          sat = v[DATA_W-1:0];
    endfunction

    function automatic logic signed [DATA_W-1:0] err_of(input logic signed [DATA_W-1:0] y,
                                                        input logic hit);
        logic signed [DATA_W:0] d;
        d = {y[DATA_W-1], y} - (hit ? {1'b0, ONE} : '0);
        err_of = sat(d);
    endfunction

    state_t                   state_q, state_d;
    logic signed [DATA_W-1:0] buf_q [N_OUT];
    logic signed [DATA_W-1:0] buf_d [N_OUT];
    logic signed [DATA_W-1:0] max_val_q, max_val_d;
    logic        [SEL_W-1:0]  max_idx_q, max_idx_d;
    logic                     first_q, first_d;
    logic        [IDX_W-1:0]  class_out_q, class_out_d;
    logic        [IDX_W-1:0]  label_q, label_d;
    logic        [IDX_W-1:0]  emit_label_q, emit_label_d;
    logic        [SEL_W-1:0]  emit_i_q, emit_i_d;
    logic signed [DATA_W-1:0] err_data_q, err_data_d;
    logic                     err_valid_q, err_valid_d;

    logic                     in_range;
    logic        [SEL_W-1:0]  wr_sel;

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        max_val_d    = max_val_q;
        max_idx_d    = max_idx_q;
        first_d      = first_q;
        class_out_d  = class_out_q;
        label_d      = bus.label_valid ? bus.label : label_q;
        emit_label_d = emit_label_q;
        emit_i_d     = emit_i_q;
        err_data_d   = err_data_q;
        err_valid_d  = err_valid_q;
        in_range     = bus.in_idx < IDX_W'(N_OUT);
        wr_sel       = bus.in_idx[SEL_W-1:0];

        case (state_q)
            COLLECT: begin
                // Out-of-range indices are accepted (in_rdy stays high) but dropped.
                if (bus.in_valid && in_range) begin
                    buf_d[wr_sel] = bus.in_data;
                    if (first_q || bus.in_data > max_val_q) begin
                        max_val_d = bus.in_data;
                        max_idx_d = wr_sel;
                    end
                    first_d = 1'b0;
                    if (bus.in_idx == IDX_W'(N_OUT-1)) begin
                        class_out_d = IDX_W'(max_idx_d);
                        state_d     = RESULT;
                    end
                end
            end
            RESULT: state_d = WAIT_BWD;
            WAIT_BWD: begin
                if (!bus.forward) begin
                    state_d      = EMIT;
                    emit_i_d     = '0;
                    emit_label_d = label_q;
                    err_data_d   = err_of(buf_q[0], label_q == '0);
                    err_valid_d  = 1'b1;
                end
            end
            EMIT: begin
                // The next error word is prepared here so err_data is a plain register.
                if (err_valid_q && bus.err_rdy) begin
                    if (emit_i_q == SEL_W'(N_OUT-1)) begin
                        err_valid_d = 1'b0;
                        state_d     = COLLECT;
                        first_d     = 1'b1;
                        max_val_d   = MOST_NEG;
                        max_idx_d   = '0;
                    end else begin
                        emit_i_d   = emit_i_q + SEL_W'(1);
                        err_data_d = err_of(buf_q[emit_i_d], IDX_W'(emit_i_d) == emit_label_q);
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= COLLECT;
            max_val_q    <= MOST_NEG;
            max_idx_q    <= '0;
            first_q      <= 1'b1;
            class_out_q  <= '0;
            label_q      <= '0;
            emit_label_q <= '0;
            emit_i_q     <= '0;
            err_data_q   <= '0;
            err_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            max_val_q    <= max_val_d;
            max_idx_q    <= max_idx_d;
            first_q      <= first_d;
            class_out_q  <= class_out_d;
            label_q      <= label_d;
            emit_label_q <= emit_label_d;
            emit_i_q     <= emit_i_d;
            err_data_q   <= err_data_d;
            err_valid_q  <= err_valid_d;
        end
    end

    // Sample buffer holds pure data and needs no reset.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign bus.in_rdy      = (state_q == COLLECT);
    assign bus.busy        = (state_q != COLLECT);
    assign bus.class_valid = (state_q == RESULT);
    assign bus.class_out   = class_out_q;
    assign bus.err_data    = err_data_q;
    assign bus.err_idx     = IDX_W'(emit_i_q);
    assign bus.err_valid   = err_valid_q;

endmodule

// File: tb/tb_fc_loss_grad.sv
// Bench for fc_loss_grad: table of directed vectors, reset-in-EMIT sequence and
// randomized vectors, all checked against a plain-arithmetic reference model.
module tb_fc_loss_grad;

    localparam int N_OUT  = 10;
    localparam int IDX_W  = 10;
    localparam int DATA_W = 32;
    localparam longint LMAX = 64'sd2147483647;
    localparam longint LMIN = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fc_loss_grad_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

    fc_loss_grad #(.N_OUT(N_OUT), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [N_OUT-1:0][31:0] y;
        logic [IDX_W-1:0]       lab;
        logic                   oob;
        logic                   fwd;
        logic [IDX_W-1:0]       exp_class;
        logic [3:0]             chk_i;
        logic [31:0]            chk_err;
    } vec_t;

    int total = 0;
    int bad   = 0;
    logic signed [31:0] cur_y [N_OUT];
    logic [31:0]        got_err [N_OUT];
    int                 cur_lab = 0;
    vec_t               tbl [7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    function automatic int model_class();
        int b = 0;
        for (int i = 1; i < N_OUT; i++) if (cur_y[i] > cur_y[b]) b = i;
        return b;
    endfunction

    function automatic logic [31:0] model_err(input logic signed [31:0] y, input int i,
                                              input int lab);
        longint d;
        d = longint'(y) - ((i == lab) ? 64'sd65536 : 64'sd0);
        if (d > LMAX) d = LMAX;
        if (d < LMIN) d = LMIN;
        return d[31:0];
    endfunction

    task automatic collect(input string tag, input int lab, input bit relatch, input bit oob,
                           input bit gaps, input bit fwd);
        bus.forward = fwd;
        check({tag, "/in_rdy"}, 32'(bus.in_rdy), 32'd1);
        for (int i = 0; i < N_OUT; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.in_valid = 1'b0;
                step();
            end
            if (oob && i == 4) begin
                bus.in_valid = 1'b1;
                bus.in_idx   = IDX_W'(12);
                bus.in_data  = 32'sh7FFF_FFFF;
                step();
            end
            bus.in_valid = 1'b1;
            bus.in_idx   = IDX_W'(i);
            bus.in_data  = cur_y[i];
            if (i == 0 && relatch) begin
                bus.label       = IDX_W'(lab);
                bus.label_valid = 1'b1;
                cur_lab         = lab;
            end
            step();
            bus.label_valid = 1'b0;
        end
        bus.in_valid = 1'b0;
        check({tag, "/class_valid"}, 32'(bus.class_valid), 32'd1);
        check({tag, "/class_out"}, 32'(bus.class_out), 32'(model_class()));
        check({tag, "/busy_result"}, 32'(bus.busy), 32'd1);
        step();
        check({tag, "/class_pulse_end"}, 32'(bus.class_valid), 32'd0);
        check({tag, "/in_rdy_wait"}, 32'(bus.in_rdy), 32'd0);
    endtask

    task automatic emit(input string tag, input int mode);
        int k = 0;
        bit held = 1'b0;
        logic [31:0] hd = '0;
        logic [31:0] hi = '0;
        int lab_e = cur_lab;
        bus.forward = 1'b0;
        step();
        check({tag, "/err_latency"}, 32'(bus.err_valid), 32'd1);
        for (int c = 0; c < 300 && k < N_OUT; c++) begin
            bit r;
            case (mode)
                0:       r = 1'b1;
                1:       r = (c % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            if (held) begin
                check($sformatf("%s/hold_valid%0d", tag, c), 32'(bus.err_valid), 32'd1);
                check($sformatf("%s/hold_data%0d", tag, c), bus.err_data, hd);
                check($sformatf("%s/hold_idx%0d", tag, c), 32'(bus.err_idx), hi);
            end
            if (bus.err_valid) begin
                if (r) begin
                    check($sformatf("%s/err_idx%0d", tag, k), 32'(bus.err_idx), 32'(k));
                    check($sformatf("%s/err_data%0d", tag, k), bus.err_data,
                          model_err(cur_y[k], k, lab_e));
                    got_err[k] = bus.err_data;
                    k++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hd   = bus.err_data;
                    hi   = 32'(bus.err_idx);
                end
            end else begin
                held = 1'b0;
            end
            if (mode == 2 && $urandom_range(0, 3) == 0) begin
                cur_lab         = $urandom_range(0, 15);
                bus.label       = IDX_W'(cur_lab);
                bus.label_valid = 1'b1;
            end
            bus.err_rdy = r;
            step();
            bus.label_valid = 1'b0;
        end
        check({tag, "/emit_count"}, 32'(k), 32'(N_OUT));
        check({tag, "/err_valid_end"}, 32'(bus.err_valid), 32'd0);
        check({tag, "/in_rdy_end"}, 32'(bus.in_rdy), 32'd1);
        check({tag, "/busy_end"}, 32'(bus.busy), 32'd0);
        bus.forward = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        bus.forward     = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.in_idx      = '0;
        bus.label       = '0;
        bus.label_valid = 1'b0;
        bus.err_rdy     = 1'b0;

        for (int e = 0; e < 7; e++) tbl[e] = '0;
        for (int i = 0; i < N_OUT; i++) begin
            tbl[0].y[i] = 32'(i * 65536);
            tbl[2].y[i] = 32'h0000_8000;
            tbl[4].y[i] = 32'(i * 4096);
            tbl[5].y[i] = 32'(-(i * 65536));
            tbl[6].y[i] = 32'h8000_0000;
        end
        tbl[0].fwd = 1'b1; tbl[0].lab = 0;  tbl[0].exp_class = 9; tbl[0].chk_i = 0; tbl[0].chk_err = 32'hFFFF_0000;
        tbl[1].y[2] = 32'h0005_0000; tbl[1].y[7] = 32'h0005_0000;
        tbl[1].fwd = 1'b1; tbl[1].lab = 7;  tbl[1].exp_class = 2; tbl[1].chk_i = 7; tbl[1].chk_err = 32'h0004_0000;
        tbl[2].fwd = 1'b0; tbl[2].lab = 3;  tbl[2].exp_class = 0; tbl[2].chk_i = 3; tbl[2].chk_err = 32'hFFFF_8000;
        tbl[3].y[0] = 32'h8000_0000;
        tbl[3].fwd = 1'b1; tbl[3].lab = 0;  tbl[3].exp_class = 1; tbl[3].chk_i = 0; tbl[3].chk_err = 32'h8000_0000;
        tbl[4].y[4] = 32'h0003_0000;
        tbl[4].fwd = 1'b1; tbl[4].lab = 15; tbl[4].oob = 1'b1; tbl[4].exp_class = 4; tbl[4].chk_i = 4; tbl[4].chk_err = 32'h0003_0000;
        tbl[5].fwd = 1'b1; tbl[5].lab = 15; tbl[5].exp_class = 0; tbl[5].chk_i = 9; tbl[5].chk_err = 32'hFFF7_0000;
        tbl[6].fwd = 1'b1; tbl[6].lab = 2;  tbl[6].exp_class = 0; tbl[6].chk_i = 2; tbl[6].chk_err = 32'h8000_0000;

        repeat (2) step();
        check("reset/in_rdy", 32'(bus.in_rdy), 32'd1);
        check("reset/class_out", 32'(bus.class_out), 32'd0);
        check("reset/class_valid", 32'(bus.class_valid), 32'd0);
        check("reset/err_data", bus.err_data, 32'd0);
        check("reset/err_idx", 32'(bus.err_idx), 32'd0);
        check("reset/err_valid", 32'(bus.err_valid), 32'd0);
        check("reset/busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        step();

        for (int e = 0; e < 7; e++) begin
            string tag;
            tag = $sformatf("vec%0d", e);
            for (int i = 0; i < N_OUT; i++) cur_y[i] = $signed(tbl[e].y[i]);
            collect(tag, int'(tbl[e].lab), 1'b1, tbl[e].oob, 1'b0, tbl[e].fwd);
            check({tag, "/class_tbl"}, 32'(bus.class_out), 32'(tbl[e].exp_class));
            emit(tag, e % 3);
            check({tag, "/err_tbl"}, got_err[tbl[e].chk_i], tbl[e].chk_err);
        end

        // Reset asserted mid-emission after three error words have gone out.
        for (int i = 0; i < N_OUT; i++) cur_y[i] = 32'(i * 65536);
        collect("rstemit", 5, 1'b1, 1'b0, 1'b0, 1'b1);
        bus.forward = 1'b0;
        bus.err_rdy = 1'b1;
        repeat (4) step();
        check("rstemit/pre_idx", 32'(bus.err_idx), 32'd3);
        #2 rst = 1'b1;
        #1;
        check("rstemit/err_valid", 32'(bus.err_valid), 32'd0);
        check("rstemit/in_rdy", 32'(bus.in_rdy), 32'd1);
        check("rstemit/class_out", 32'(bus.class_out), 32'd0);
        check("rstemit/busy", 32'(bus.busy), 32'd0);
        step();
        rst         = 1'b0;
        bus.forward = 1'b1;
        bus.err_rdy = 1'b0;
        for (int i = 0; i < N_OUT; i++) cur_y[i] = 32'((N_OUT - i) * 32768);
        collect("fresh", 6, 1'b1, 1'b0, 1'b0, 1'b1);
        emit("fresh", 0);

        for (int t = 0; t < 8; t++) begin
            int kind;
            string tag;
            tag  = $sformatf("rnd%0d", t);
            kind = $urandom_range(0, 3);
            for (int i = 0; i < N_OUT; i++) begin
                case (kind)
                    0:       cur_y[i] = $signed($urandom());
                    1:       cur_y[i] = $signed(32'($urandom_range(0, 32'h000F_FFFF)) - 32'h0008_0000);
                    2:       cur_y[i] = $signed(32'($urandom_range(0, 2)) << 16);
                    default: cur_y[i] = $signed(32'h8000_0000 + 32'($urandom_range(0, 32'h0002_0000)));
                endcase
            end
            collect(tag, $urandom_range(0, 15), 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            emit(tag, 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fc_loss_grad.md
Name: fc_loss_grad

Overview:
- Sits directly downstream of the fc layer.
- Forward pass: consumes the fc layer's indexed Q16.16 output stream (N_OUT values), buffers them and reports the argmax class.
- Backward pass: streams the error vector err[i] = y[i] - t[i] back to the fc layer, indexed 0..N_OUT-1, where t is the one-hot target for the latched label.

Parameters:
N_OUT, 10, number of fc outputs/classes
IDX_W, 10, width of index buses
DATA_W, 32, data width, signed Q16.16 (1.0 = 32'h0001_0000)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
forward  in  1  1 = forward pass, 0 = backward pass (shared with fc layer)
in_valid  in  1  fc_output/fc_out_idx valid
in_data  in  DATA_W  fc output value (signed Q16.16)
in_idx  in  IDX_W  fc output index
in_rdy  out  1  block accepts a sample this cycle (drives fc out_rdy)
label  in  IDX_W  target class
label_valid  in  1  latch label this cycle
class_out  out  IDX_W  argmax index of last collected vector
class_valid  out  1  one-cycle pulse when class_out updates
err_data  out  DATA_W  error value, signed Q16.16
err_idx  out  IDX_W  error index
err_valid  out  1  err_data/err_idx valid
err_rdy  in  1  downstream (fc backward input) accepts error sample
busy  out  1  high in any state other than COLLECT

Behaviour:
- Reset, asynchronous, any state: state=COLLECT; buffer contents don't-care; max_val=most negative; max_idx=0; label register=0.
- Reset output values: in_rdy=1, class_out=0, class_valid=0, err_data=0, err_idx=0, err_valid=0, busy=0.
- Label: label_valid=1 latches label on any cycle and in any state.
- Label used by EMIT is the value latched at entry to EMIT.
- label >= N_OUT gives an all-zero target, so err = y.
- COLLECT:
  - in_rdy=1; a sample is accepted when in_valid && in_rdy.
  - in_idx < N_OUT: buffer[in_idx] <= in_data.
  - Running argmax update: strict signed greater-than, so ties keep the lower (earlier) index. The first accepted sample after entering COLLECT always loads max.
  - in_idx >= N_OUT: sample is accepted and dropped.
  - Accepting in_idx == N_OUT-1 moves to RESULT next cycle.
  - Samples arrive in index order by contract.
- RESULT (1 cycle): in_rdy=0; class_out <= max_idx; class_valid pulses for exactly this cycle; next state WAIT_BWD.
- WAIT_BWD: in_rdy=0; waits for forward==0, then enters EMIT with err index i=0.
- EMIT:
  - err_valid=1; err_idx=i; err_data=sat(buffer[i] - (i==label ? 32'h0001_0000 : 0)).
  - Output is registered: err_data/err_idx are stable while err_valid && !err_rdy.
  - On err_valid && err_rdy: i advances. Throughput is 1 sample/cycle with err_rdy held high.
  - Accepting i == N_OUT-1: err_valid drops the next cycle, then move to COLLECT, reset max, in_rdy=1.
- Arithmetic: 33-bit signed subtraction, saturated to [32'h8000_0000, 32'h7FFF_FFFF].
- forward rising while in EMIT: the emission still completes; it is not aborted.
- forward==0 while in COLLECT: samples are still accepted; no special handling.
- Latency: last forward sample accepted -> class_valid 1 cycle later. forward low -> first err_valid within 1 cycle.
- busy = (state != COLLECT).

Test Plan:
- Reset mid-EMIT (after 3 errors sent) -> next cycle err_valid=0, in_rdy=1, class_out=0; a fresh 10-sample vector then collects normally.
- Forward vector y[i]=i*1.0 (i*32'h0001_0000), i=0..9, in_valid held high -> class_valid pulses once, 1 cycle after idx 9, class_out=9; busy=1 from that cycle.
- Tie: y[2]=y[7]=5.0 (max), others 0 -> class_out=2.
- label=3, y[i]=0.5 (32'h0000_8000), forward driven 0, err_rdy=1 -> 10 consecutive outputs err_idx 0..9. err_data=32'h0000_8000 except idx 3 = 32'hFFFF_8000 (-0.5).
- err_rdy toggling 1,0,0,1... -> each err sample is held stable while stalled; none skipped or duplicated.
- Saturation: y[0]=32'h8000_0000, label=0 -> err_data=32'h8000_0000.
- Out-of-range: idx 12 interleaved in the stream -> ignored, argmax unchanged.
- Label >= N_OUT (label=15) -> err = y for all indices.
